pairwise_gate_sched: RTL and testbench
======================================

PAIRWISE_GATE_SCHED -- requirements
Module: pairwise_gate_sched

Interface
REQ-001 SHALL have parameter: nbits, 100, input vector width (minimum 2); result width is nbits-1.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req0_val input 1, req0_rdy output 1, req0_op input 2, req0_data input nbits; requester 0 val/rdy channel.
REQ-005 SHALL have ports: req1_val input 1, req1_rdy output 1, req1_op input 2, req1_data input nbits; requester 1 val/rdy channel.
REQ-006 SHALL have ports: resp_val output 1, resp_rdy input 1, resp_id output 1 (granted requester), resp_data output nbits-1 (result).
REQ-007 SHALL have ports, present only with PAIRWISE_STATS_EN: stat_cnt0 output 16, stat_cnt1 output 16; completed responses per requester.

Function
REQ-008 SHALL share one pairwise gate unit between both requesters, with one transaction in flight at a time.
REQ-009 SHALL decode op as: 00 AND, 01 OR, 10 XNOR, 11 XOR; result bit i = f(data[i], data[i+1]) for i = 0..nbits-2.
REQ-010 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE.
REQ-011 SHALL, in IDLE, assert rdy only on the granted requester, combinationally from val and the priority pointer; rdy SHALL be 0 in CALC and RESP.
REQ-012 SHALL arbitrate round-robin: if only one val is high, grant it; if both are high, grant the requester named by the priority pointer.
REQ-013 SHALL capture op, data and id on the val&rdy cycle, go to CALC, and move the priority pointer to the non-granted requester.
REQ-014 SHALL, in CALC, compute and register resp_data, then go to RESP the next cycle.
REQ-015 SHALL, in RESP, hold resp_val=1 with resp_data and resp_id stable until resp_rdy=1, then return to IDLE.
REQ-016 SHALL give resp_val a latency of exactly 2 cycles after the accept edge; peak throughput is one transaction per 3 cycles.
REQ-017 SHALL NOT accept a new request in the same cycle that a response completes.
REQ-018 SHALL leave requester signals unused when val=0; data and op changes while not granted SHALL have no effect.
REQ-019 SHALL ignore resp_rdy outside RESP.

Reset
REQ-020 SHALL, when reset_n=0 at a clock edge, set state to IDLE, the priority pointer to requester 0, and resp_val, resp_id and resp_data to 0.
REQ-021 SHALL hold req0_rdy and req1_rdy at 0 while reset_n=0.
REQ-022 SHALL abort an in-flight transaction on reset mid-operation with no response issued.
REQ-023 SHALL clear stat_cnt0 and stat_cnt1 to 0 on reset.

Configuration
REQ-024 SHALL, with PAIRWISE_STATS_EN defined, increment stat_cnt<resp_id> by 1 on each resp_val&resp_rdy, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL, without PAIRWISE_STATS_EN, omit the stat ports and counters; all other behaviour SHALL be identical.

Verification
REQ-026 SHALL cover single request: req0 op=00, data=all ones -> resp_val 2 cycles later, resp_data=all ones (99 bits), resp_id=0.
REQ-027 SHALL cover op coverage: data=...0101 alternating, ops 00/01/10/11 -> results all 0 / all 1 / all 0 / all 1.
REQ-028 SHALL cover contention: both val held high for 4 transactions -> grants 0,1,0,1; rdy never high on both requesters at once.
REQ-029 SHALL cover backpressure: resp_rdy=0 for 5 cycles in RESP -> resp_val, resp_data and resp_id stable; both rdy=0; completion on resp_rdy=1.
REQ-030 SHALL cover reset mid-op: reset_n=0 during CALC -> resp_val=0 and pointer=0 next cycle; the first post-reset grant with both val high goes to req0.
REQ-031 SHALL cover stats (PAIRWISE_STATS_EN): 3 req1 completions -> stat_cnt1=3, stat_cnt0=0; preload to 0xFFFF plus one completion -> 0.

Source files
------------

// File: rtl/pairwise_gate_sched.sv
// -----------------------------------------------------------------------------
// pairwise_gate_sched
//
// Purpose:
//   One shared pairwise gate unit serving two requesters over val/rdy
//   channels. A granted request is captured in IDLE, the result is
//   computed and registered in CALC, and the result is presented in RESP
//   until the consumer takes it. Only one transaction is in flight at a
//   time. Result bit i is f(data[i], data[i+1]) with f chosen by op:
//   00 AND, 01 OR, 10 XNOR, 11 XOR.
//
// Parameters:
//   nbits      input vector width (minimum 2); result width is nbits-1
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   req0_*     requester 0: val (in), rdy (out), op[1:0] (in), data (in)
//   req1_*     requester 1: val (in), rdy (out), op[1:0] (in), data (in)
//   resp_val   response valid (out)
//   resp_rdy   response ready from consumer (in)
//   resp_id    requester the response belongs to (out)
//   resp_data  pairwise result, nbits-1 bits (out)
//   stat_cnt0  completed responses for requester 0 (PAIRWISE_STATS_EN only)
//   stat_cnt1  completed responses for requester 1 (PAIRWISE_STATS_EN only)
//
// Build option:
//   PAIRWISE_STATS_EN  when defined, adds the 16-bit wrapping completion
//                      counters and their output ports.
// -----------------------------------------------------------------------------
module pairwise_gate_sched #(
    parameter int nbits = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [1:0]       req0_op,
    input  logic [nbits-1:0] req0_data,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [1:0]       req1_op,
    input  logic [nbits-1:0] req1_data,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_id,
    output logic [nbits-2:0] resp_data
`ifdef PAIRWISE_STATS_EN
    ,
    output logic [15:0]      stat_cnt0,
    output logic [15:0]      stat_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;        // requester favoured when both are valid
    logic             r_id;
    logic [1:0]       r_op;
    logic [nbits-1:0] r_data;
    logic [nbits-2:0] r_resp_data;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_idle;
    logic             w_accept;

    // Adjacent-bit gate: result[i] = f(d[i], d[i+1]).
    function automatic logic [nbits-2:0] gate_vec(input logic [1:0]       op,
                                                  input logic [nbits-1:0] d);
        logic [nbits-2:0] res;
        res = {(nbits-1){1'b0}};
        for (int i = 0; i < nbits - 1; i++) begin
            case (op)
                2'b00:   res[i] = d[i] & d[i+1];
                2'b01:   res[i] = d[i] | d[i+1];
                2'b10:   res[i] = ~(d[i] ^ d[i+1]);
                default: res[i] = d[i] ^ d[i+1];
            endcase
        end
        return res;
    endfunction

    // Round-robin grant: a lone valid requester wins, a tie goes to r_ptr.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_val && req1_val) begin
            if (r_ptr) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else begin
            w_gnt0 = req0_val;
            w_gnt1 = req1_val;
        end
    end

    // rdy is gated by reset so nothing looks acceptable while reset_n is low.
    assign w_idle   = (r_state == ST_IDLE) && reset_n;
    assign req0_rdy = w_idle && w_gnt0;
    assign req1_rdy = w_idle && w_gnt1;
    assign w_accept = (req0_val && req0_rdy) || (req1_val && req1_rdy);

    assign resp_val  = (r_state == ST_RESP);
    assign resp_id   = r_id;
    assign resp_data = r_resp_data;

    // Next-state logic; resp_rdy only matters in RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_CALC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CALC: w_next = ST_RESP;
            ST_RESP: begin
                if (resp_rdy) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, request capture, pointer update and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_op        <= 2'b00;
            r_data      <= {nbits{1'b0}};
            r_resp_data <= {(nbits-1){1'b0}};
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= w_gnt1 ? req1_op   : req0_op;
                r_data <= w_gnt1 ? req1_data : req0_data;
                r_id   <= w_gnt1;
                // The loser of this round becomes favoured for the next tie.
                r_ptr  <= ~w_gnt1;
            end
            if (r_state == ST_CALC) begin
                r_resp_data <= gate_vec(r_op, r_data);
            end
        end
    end

`ifdef PAIRWISE_STATS_EN
    logic [15:0] r_stat_cnt0;
    logic [15:0] r_stat_cnt1;

    // Per-requester completion counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_cnt0 <= 16'd0;
            r_stat_cnt1 <= 16'd0;
        end else if (resp_val && resp_rdy) begin
            if (r_id) begin
                r_stat_cnt1 <= r_stat_cnt1 + 16'd1;
            end else begin
                r_stat_cnt0 <= r_stat_cnt0 + 16'd1;
            end
        end
    end

    assign stat_cnt0 = r_stat_cnt0;
    assign stat_cnt1 = r_stat_cnt1;
`endif

endmodule

// File: tb/tb_pairwise_gate_sched.sv
// -----------------------------------------------------------------------------
// tb_pairwise_gate_sched
//
// Self-checking bench for pairwise_gate_sched (nbits = 100). A behavioural
// model computes results with whole-vector arithmetic and tracks the
// round-robin pointer and completion counts from the arbitration rules.
// Define PAIRWISE_STATS_EN for both files to include the counter checks.
// -----------------------------------------------------------------------------
module tb_pairwise_gate_sched;

    localparam int NB = 100;

    logic          clk;
    logic          reset_n;
    logic          req0_val;
    logic          req0_rdy;
    logic [1:0]    req0_op;
    logic [NB-1:0] req0_data;
    logic          req1_val;
    logic          req1_rdy;
    logic [1:0]    req1_op;
    logic [NB-1:0] req1_data;
    logic          resp_val;
    logic          resp_rdy;
    logic          resp_id;
    logic [NB-2:0] resp_data;
`ifdef PAIRWISE_STATS_EN
    logic [15:0]   stat_cnt0;
    logic [15:0]   stat_cnt1;
`endif

    int n_checks;
    int n_errors;

    // Reference state: who wins the next tie, and completions per requester.
    int          m_ptr;
    logic [15:0] m_cnt0;
    logic [15:0] m_cnt1;

    pairwise_gate_sched #(.nbits(NB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_val  (req0_val),
        .req0_rdy  (req0_rdy),
        .req0_op   (req0_op),
        .req0_data (req0_data),
        .req1_val  (req1_val),
        .req1_rdy  (req1_rdy),
        .req1_op   (req1_op),
        .req1_data (req1_data),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_id   (resp_id),
        .resp_data (resp_data)
`ifdef PAIRWISE_STATS_EN
        ,
        .stat_cnt0 (stat_cnt0),
        .stat_cnt1 (stat_cnt1)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-vector model: pair each bit with its upper neighbour by shifting.
    function automatic logic [NB-2:0] model_result(input logic [1:0]    op,
                                                   input logic [NB-1:0] d);
        logic [NB-2:0] lo;
        logic [NB-2:0] hi;
        lo = d[NB-2:0];
        hi = d[NB-1:1];
        case (op)
            2'b00:   return lo & hi;
            2'b01:   return lo | hi;
            2'b10:   return ~(lo ^ hi);
            default: return lo ^ hi;
        endcase
    endfunction

    function automatic logic [NB-1:0] rand_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NB-1:0];
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef PAIRWISE_STATS_EN
        check_value("stat_cnt0", 128'(stat_cnt0), 128'(m_cnt0));
        check_value("stat_cnt1", 128'(stat_cnt1), 128'(m_cnt1));
`endif
    endtask

    // One full transaction from IDLE with bp cycles of response backpressure.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [1:0] o0, input logic [1:0] o1,
                           input logic [NB-1:0] d0, input logic [NB-1:0] d1,
                           input int bp);
        int            g;
        logic [NB-2:0] exp_res;
        req0_val  = v0;
        req1_val  = v1;
        req0_op   = o0;
        req1_op   = o1;
        req0_data = d0;
        req1_data = d1;
        #1;
        if (!v0 && !v1) begin
            check_value("idle_rdy0", 128'(req0_rdy), 128'(0));
            check_value("idle_rdy1", 128'(req1_rdy), 128'(0));
            step();
            check_value("idle_resp_val", 128'(resp_val), 128'(0));
            return;
        end
        if (v0 && v1) g = m_ptr;
        else if (v0)  g = 0;
        else          g = 1;
        exp_res = model_result((g == 1) ? o1 : o0, (g == 1) ? d1 : d0);
        check_value("grant_rdy0", 128'(req0_rdy), 128'(g == 0));
        check_value("grant_rdy1", 128'(req1_rdy), 128'(g == 1));
        step();
        m_ptr = 1 - g;
        // CALC: nothing visible yet; scribble on requester inputs and resp_rdy.
        check_value("calc_resp_val", 128'(resp_val), 128'(0));
        check_value("calc_rdy0", 128'(req0_rdy), 128'(0));
        check_value("calc_rdy1", 128'(req1_rdy), 128'(0));
        req0_data = rand_data();
        req1_data = rand_data();
        req0_op   = 2'($urandom_range(3, 0));
        req1_op   = 2'($urandom_range(3, 0));
        resp_rdy  = 1'($urandom_range(1, 0));
        step();
        check_value("resp_val", 128'(resp_val), 128'(1));
        check_value("resp_id", 128'(resp_id), 128'(g));
        check_value("resp_data", 128'(resp_data), 128'(exp_res));
        resp_rdy = 1'b0;
        for (int k = 0; k < bp; k++) begin
            step();
            check_value("bp_resp_val", 128'(resp_val), 128'(1));
            check_value("bp_resp_id", 128'(resp_id), 128'(g));
            check_value("bp_resp_data", 128'(resp_data), 128'(exp_res));
            check_value("bp_rdy_both", 128'({req0_rdy, req1_rdy}), 128'(0));
        end
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
        if (g == 1) m_cnt1 = m_cnt1 + 16'd1;
        else        m_cnt0 = m_cnt0 + 16'd1;
        check_value("done_resp_val", 128'(resp_val), 128'(0));
        check_stats();
    endtask

    logic [NB-1:0] ones;
    logic [NB-1:0] alt;
    int            n_grants_overlap;

    // Monitor: the two rdy outputs must never be high together.
    always @(negedge clk) begin
        if (req0_rdy && req1_rdy) n_grants_overlap++;
    end

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        n_grants_overlap = 0;
        m_ptr            = 0;
        m_cnt0           = 16'd0;
        m_cnt1           = 16'd0;
        ones             = {NB{1'b1}};
        for (int i = 0; i < NB; i++) alt[i] = (i % 2 == 0);

        // Reset with both requesters valid: rdy must stay low.
        reset_n   = 1'b0;
        req0_val  = 1'b1;
        req1_val  = 1'b1;
        req0_op   = 2'b00;
        req1_op   = 2'b00;
        req0_data = ones;
        req1_data = ones;
        resp_rdy  = 1'b1;
        step();
        step();
        check_value("rst_resp_val", 128'(resp_val), 128'(0));
        check_value("rst_resp_id", 128'(resp_id), 128'(0));
        check_value("rst_resp_data", 128'(resp_data), 128'(0));
        check_value("rst_rdy0", 128'(req0_rdy), 128'(0));
        check_value("rst_rdy1", 128'(req1_rdy), 128'(0));
        check_stats();
        req0_val = 1'b0;
        req1_val = 1'b0;
        resp_rdy = 1'b0;
        reset_n  = 1'b1;
        step();

        // Three completions from requester 1 only.
        for (int i = 0; i < 3; i++)
            run_txn(1'b0, 1'b1, 2'b00, 2'($urandom_range(3, 0)), rand_data(), rand_data(), 0);
        check_value("req1_only_cnt1", 128'(m_cnt1), 128'(3));

        // Single request, AND of all ones.
        run_txn(1'b1, 1'b0, 2'b00, 2'b11, ones, rand_data(), 0);
        check_value("and_ones_const", 128'(resp_data), 128'({(NB-1){1'b1}}));

        // Alternating pattern through every op.
        for (int op = 0; op < 4; op++)
            run_txn(1'b1, 1'b0, 2'(op), 2'b00, alt, rand_data(), 0);

        // Contention: both valid for four rounds.
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                    rand_data(), rand_data(), 0);

        // Backpressure: five cycles of resp_rdy low in RESP.
        run_txn(1'b0, 1'b1, 2'b00, 2'b10, rand_data(), rand_data(), 5);

        // Randomised traffic.
        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                    rand_data(), rand_data(), int'($urandom_range(3, 0)));

        // Reset during CALC: no response, pointer back to requester 0.
        req0_val  = 1'b1;
        req1_val  = 1'b0;
        req0_op   = 2'b01;
        req0_data = rand_data();
        #1;
        check_value("mid_accept_rdy0", 128'(req0_rdy), 128'(1));
        step();
        check_value("mid_calc_resp_val", 128'(resp_val), 128'(0));
        reset_n  = 1'b0;
        req1_val = 1'b1;
        resp_rdy = 1'b1;
        step();
        m_ptr  = 0;
        m_cnt0 = 16'd0;
        m_cnt1 = 16'd0;
        check_value("mid_rst_resp_val", 128'(resp_val), 128'(0));
        check_value("mid_rst_rdy_both", 128'({req0_rdy, req1_rdy}), 128'(0));
        check_value("mid_rst_resp_data", 128'(resp_data), 128'(0));
        step();
        check_value("mid_rst_hold_resp_val", 128'(resp_val), 128'(0));
        check_stats();
        reset_n  = 1'b1;
        resp_rdy = 1'b0;
        run_txn(1'b1, 1'b1, 2'b11, 2'b00, rand_data(), rand_data(), 0);
        check_value("post_rst_grant", 128'(resp_id), 128'(0));

`ifdef PAIRWISE_STATS_EN
        // Counter wrap: preload requester 1 counter to its maximum.
        dut.r_stat_cnt1 = 16'hFFFF;
        m_cnt1          = 16'hFFFF;
        run_txn(1'b0, 1'b1, 2'b00, 2'b01, rand_data(), rand_data(), 0);
        check_value("stat_wrap", 128'(stat_cnt1), 128'(0));
`endif

        check_value("rdy_overlap", 128'(n_grants_overlap), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
